// File: rtl/any1_ialign_buf.sv
// rtl/any1_ialign_buf.sv - multi-issue instruction aligner with sequential line buffer
// Extracts up to NWAY consecutive instructions from buffered cache lines starting at ip.
module any1_ialign_buf #(
  parameter int                   LINE_BITS = 512,
  parameter int                   INSN_BITS = 32,
  parameter int                   NWAY      = 2,
  parameter int                   DEPTH     = 2,
  parameter int                   AW        = 32,
  parameter logic [AW-1:0]        RESET_IP  = 'hFFFC0000,
  parameter logic [INSN_BITS-1:0] FAULT_IR  = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redir,
  input  logic [AW-1:0]             redir_ip,
  input  logic [2:0]                redir_stream,
  input  logic                      line_valid,
  output logic                      line_ready,
  input  logic [AW-1:0]             line_adr,
  input  logic [LINE_BITS-1:0]      line_data,
  output logic [NWAY-1:0]           out_valid,
  output logic [NWAY*INSN_BITS-1:0] out_ir,
  output logic [NWAY*AW-1:0]        out_ip,
  output logic                      out_fault,
  output logic [2:0]                out_stream,
  input  logic                      out_ready
);

  localparam int LB  = LINE_BITS / 8;
  localparam int IB  = INSN_BITS / 8;
  localparam int LBW = $clog2(LB);
  localparam int IBW = $clog2(IB);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int NW  = $clog2(NWAY + 1);
  localparam logic [AW-1:0] LINE_MASK = ~(AW'(LB - 1));
  localparam logic [AW-1:0] INSN_MASK = AW'(IB - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t                 state, state_nxt;
  logic [AW-1:0]          ip, exp_adr;
  logic [2:0]             stream;
  logic [LINE_BITS-1:0]   buf_data [DEPTH];
  logic [AW-1:0]          buf_adr  [DEPTH];
  logic [PW-1:0]          rd_ptr, wr_ptr, nx_ptr;
  logic [CW-1:0]          count, count_nxt;
  logic                   ready_q;

  logic [NWAY-1:0]           slot_valid;
  logic [NWAY*INSN_BITS-1:0] slot_ir;
  logic [NW-1:0]             n_valid;
  logic [AW-1:0]             ip_nxt, new_line;
  logic                      consume, push, has_one, has_two;
  logic [1:0]                pop_n;

  assign nx_ptr     = rd_ptr + PW'(1);
  assign has_one    = count != '0;
  assign has_two    = count > CW'(1);
  assign line_ready = ready_q;
  assign out_stream = stream;

  // Each slot may hit the head line or the following entry; validity chains from slot 0.
  always_comb begin
    logic [AW-1:0]        a;
    logic [AW-1:0]        la;
    logic                 hit_head, hit_next, chain;
    logic [LBW-IBW-1:0]   idx;
    a          = '0;
    la         = '0;
    hit_head   = 1'b0;
    hit_next   = 1'b0;
    idx        = '0;
    chain      = (state == RUN);
    slot_valid = '0;
    slot_ir    = '0;
    n_valid    = '0;
    for (int k = 0; k < NWAY; k++) begin
      a        = ip + AW'(k * IB);
      la       = a & LINE_MASK;
      hit_head = has_one && (la == buf_adr[rd_ptr]);
      hit_next = has_two && (la == buf_adr[nx_ptr]);
      idx      = a[LBW-1:IBW];
      chain    = chain && (hit_head || hit_next);
      slot_valid[k] = chain;
      if (chain) begin
        slot_ir[k*INSN_BITS +: INSN_BITS] = hit_head
          ? buf_data[rd_ptr][int'(idx)*INSN_BITS +: INSN_BITS]
          : buf_data[nx_ptr][int'(idx)*INSN_BITS +: INSN_BITS];
        n_valid = n_valid + NW'(1);
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_ir    = '0;
    out_ip    = '0;
    out_fault = 1'b0;
    if (state == FAULT) begin
      out_valid             = NWAY'(1);
      out_ir[INSN_BITS-1:0] = FAULT_IR;
      out_ip[AW-1:0]        = ip;
      out_fault             = 1'b1;
    end else begin
      out_valid = slot_valid;
      out_ir    = slot_ir;
      for (int k = 0; k < NWAY; k++)
        out_ip[k*AW +: AW] = slot_valid[k] ? ip + AW'(k * IB) : '0;
    end
  end

  assign consume  = out_ready && slot_valid[0] && (state == RUN);
  assign ip_nxt   = ip + (AW'(n_valid) << IBW);
  assign new_line = ip_nxt & LINE_MASK;
  assign push     = line_valid && ready_q && !redir && (line_adr == exp_adr);

  // Pop every entry the advanced ip has walked past.
  always_comb begin
    pop_n = 2'd0;
    if (consume && new_line != buf_adr[rd_ptr]) begin
      pop_n = 2'd1;
      if (has_two && new_line != buf_adr[nx_ptr])
        pop_n = 2'd2;
    end
  end

  assign count_nxt = count + CW'(push) - CW'(pop_n);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if ((ip & INSN_MASK) != '0)
          state_nxt = FAULT;
        else if (push)
          state_nxt = RUN;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ip      <= RESET_IP;
      exp_adr <= RESET_IP & LINE_MASK;
      stream  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else if (redir) begin
      state   <= IDLE;
      ip      <= redir_ip;
      exp_adr <= redir_ip & LINE_MASK;
      stream  <= redir_stream;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else begin
      state <= state_nxt;
      if (consume)
        ip <= ip_nxt;
      if (push)
        exp_adr <= exp_adr + AW'(LB);
      rd_ptr  <= rd_ptr + PW'(pop_n);
      wr_ptr  <= wr_ptr + PW'(push);
      count   <= count_nxt;
      ready_q <= count_nxt < DEPTH_C;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= line_data;
      buf_adr[wr_ptr]  <= line_adr;
    end
  end

endmodule

// File: tb/tb_any1_ialign_buf.sv
// tb/tb_any1_ialign_buf.sv - directed table-driven bench for any1_ialign_buf
// Line word i at address A holds {A[15:0], i[15:0]}.
module tb_any1_ialign_buf;

  logic         clk = 1'b0;
  logic         rst, redir, line_valid, out_ready, line_ready, out_fault;
  logic [31:0]  redir_ip, line_adr;
  logic [2:0]   redir_stream, out_stream;
  logic [511:0] line_data;
  logic [1:0]   out_valid;
  logic [63:0]  out_ir, out_ip;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  any1_ialign_buf dut (
    .clk(clk), .rst(rst), .redir(redir), .redir_ip(redir_ip), .redir_stream(redir_stream),
    .line_valid(line_valid), .line_ready(line_ready), .line_adr(line_adr), .line_data(line_data),
    .out_valid(out_valid), .out_ir(out_ir), .out_ip(out_ip), .out_fault(out_fault),
    .out_stream(out_stream), .out_ready(out_ready)
  );

  typedef struct {
    logic [31:0] rip;
    int          nlines;
    logic [1:0]  v;
    logic [31:0] ir0;
    logic [31:0] ir1;
    logic        f;
    logic [1:0]  v_after;
    logic [31:0] ip0_after;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_line(input logic [31:0] adr);
    logic [511:0] d;
    for (int i = 0; i < 16; i++)
      d[i*32 +: 32] = {adr[15:0], 16'(i)};
    return d;
  endfunction

  task automatic push(input logic [31:0] adr);
    line_valid = 1'b1;
    line_adr   = adr;
    line_data  = mk_line(adr);
    step();
    line_valid = 1'b0;
  endtask

  task automatic do_redir(input logic [31:0] adr, input logic [2:0] strm);
    redir        = 1'b1;
    redir_ip     = adr;
    redir_stream = strm;
    step();
    redir = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h1240, 1, 2'b11, 32'h12400000, 32'h12400001, 1'b0, 2'b11, 32'h1248};
    vecs[1] = '{32'h127C, 2, 2'b11, 32'h1240000F, 32'h12800000, 1'b0, 2'b11, 32'h1284};
    vecs[2] = '{32'h127C, 1, 2'b01, 32'h1240000F, 32'h0,        1'b0, 2'b00, 32'h0};
    vecs[3] = '{32'h1278, 1, 2'b11, 32'h1240000E, 32'h1240000F, 1'b0, 2'b00, 32'h0};
    vecs[4] = '{32'h1102, 1, 2'b01, 32'h0,        32'h0,        1'b1, 2'b01, 32'h1102};
    vecs[5] = '{32'h1100, 0, 2'b00, 32'h0,        32'h0,        1'b0, 2'b00, 32'h0};
    vecs[6] = '{32'h2004, 2, 2'b11, 32'h20000001, 32'h20000002, 1'b0, 2'b11, 32'h200C};

    rst = 1'b1; redir = 1'b0; redir_ip = '0; redir_stream = '0;
    line_valid = 1'b0; line_adr = '0; line_data = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_flags", {61'h0, out_fault, line_ready, 1'b0}, {61'h0, 1'b0, 1'b1, 1'b0});
    chk("rst_stream", 64'(out_stream), 64'h0);
    chk("rst_ir_ip", out_ir | out_ip, 64'h0);
    rst = 1'b0;

    // Wrong line address in IDLE is dropped; correct one opens the stream.
    push(32'hFFFC0040);
    chk("drop_idle_valid", 64'(out_valid), 64'h0);
    push(32'hFFFC0000);
    chk("t1_valid", 64'(out_valid), 64'h3);
    chk("t1_ir", out_ir, 64'h00000001_00000000);
    chk("t1_ip", out_ip, 64'hFFFC0004_FFFC0000);

    for (int i = 0; i < 7; i++) begin
      logic [31:0] base;
      out_ready = 1'b0;
      line_valid = 1'b0;
      do_redir(vecs[i].rip, 3'(i + 1));
      base = vecs[i].rip & 32'hFFFF_FFC0;
      for (int j = 0; j < vecs[i].nlines; j++)
        push(base + 32'(j * 64));
      step();
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vecs[i].v));
      chk($sformatf("v%0d_ir", i), out_ir, {vecs[i].ir1, vecs[i].ir0});
      chk($sformatf("v%0d_ip", i), out_ip,
          {vecs[i].v[1] ? vecs[i].rip + 32'd4 : 32'h0, vecs[i].v[0] ? vecs[i].rip : 32'h0});
      chk($sformatf("v%0d_fault", i), 64'(out_fault), 64'(vecs[i].f));
      chk($sformatf("v%0d_stream", i), 64'(out_stream), 64'(i + 1));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk($sformatf("v%0d_valid_after", i), 64'(out_valid), 64'(vecs[i].v_after));
      chk($sformatf("v%0d_ip_after", i), 64'(out_ip[31:0]), 64'(vecs[i].ip0_after));
    end

    // Dropped push leaves exp_adr alone; consume-pop with a push keeps the entry count.
    do_redir(32'h5038, 3'd3);
    push(32'h5000);
    push(32'h5080);
    chk("drop_ready", 64'(line_ready), 64'h1);
    chk("drop_valid", 64'(out_valid), 64'h3);
    push(32'h5040);
    chk("full_ready", 64'(line_ready), 64'h0);
    chk("full_ir", out_ir, 64'h5000000F_5000000E);
    out_ready = 1'b1;
    line_valid = 1'b1; line_adr = 32'h5080; line_data = mk_line(32'h5080);
    step();
    out_ready = 1'b0; line_valid = 1'b0;
    chk("cross_ip", 64'(out_ip[31:0]), 64'h5040);
    chk("cross_ir", 64'(out_ir[31:0]), 64'h50400000);
    chk("cross_ready", 64'(line_ready), 64'h1);
    out_ready = 1'b1;
    repeat (7) step();
    out_ready = 1'b0;
    chk("walk_ip", out_ip, 64'h0000507C_00005078);
    out_ready = 1'b1;
    line_valid = 1'b1; line_adr = 32'h5080; line_data = mk_line(32'h5080);
    step();
    out_ready = 1'b0; line_valid = 1'b0;
    chk("pushpop_ip", 64'(out_ip[31:0]), 64'h5080);
    chk("pushpop_ir", 64'(out_ir[31:0]), 64'h50800000);
    chk("pushpop_ready", 64'(line_ready), 64'h1);
    push(32'h50C0);
    chk("pushpop_count", 64'(line_ready), 64'h0);

    // Misaligned redirect faults and holds under consume.
    do_redir(32'h102, 3'd5);
    step();
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("fault_hold%0d", c), {27'h0, out_fault, out_valid, out_stream, out_ip[31:0]},
          {27'h0, 1'b1, 2'b01, 3'd5, 32'h102});
      chk($sformatf("fault_ir%0d", c), 64'(out_ir[31:0]), 64'h0);
      step();
    end
    out_ready = 1'b0;
    do_redir(32'h100, 3'd5);
    chk("fault_clear", {62'h0, out_fault, out_valid[0]}, 64'h0);

    // Line offered during redirect is discarded; address wraps through zero.
    redir = 1'b1; redir_ip = 32'hFFFFFFFC; redir_stream = 3'd6;
    line_valid = 1'b1; line_adr = 32'h100; line_data = mk_line(32'h100);
    step();
    redir = 1'b0; line_valid = 1'b0;
    chk("redir_line_valid", 64'(out_valid), 64'h0);
    chk("redir_stream", 64'(out_stream), 64'h6);
    step();
    chk("redir_line_empty", 64'(out_valid), 64'h0);
    push(32'hFFFFFFC0);
    chk("wrap_one_valid", 64'(out_valid), 64'h1);
    chk("wrap_one_ip", out_ip, 64'h00000000_FFFFFFFC);
    push(32'h0);
    chk("wrap_two_valid", 64'(out_valid), 64'h3);
    chk("wrap_two_ir", out_ir, 64'h00000000_FFC0000F);
    chk("wrap_two_ip", out_ip, 64'h00000000_FFFFFFFC);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("wrap_cons_ip", out_ip, 64'h00000008_00000004);
    chk("wrap_cons_ir", out_ir, 64'h00000002_00000001);

    // Reset mid-operation drops everything.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst", {59'h0, out_valid, out_stream}, 64'h0);
    chk("mid_rst_ready", 64'(line_ready), 64'h1);
    push(32'hFFFC0000);
    chk("mid_rst_ip", out_ip, 64'hFFFC0004_FFFC0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
